// File: rtl/inst_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_buf
// Description : IF-stage fetch buffer; issues in-order memory requests, pairs
//               returned words with their pc and feeds the IF/ID registers.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          ce,
    input  logic [5:0]    stall,
    input  logic          flush,
    output logic          stallreq_if,
    output logic          inst_req,
    output logic [AW-1:0] inst_addr,
    input  logic          inst_gnt,
    input  logic          inst_rvalid,
    input  logic [DW-1:0] inst_rdata,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst,
    output logic          id_valid
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]    c_DEPTH   = (c_CNT_W + 1)'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);

    logic [AW-1:0]      r_slot_pc   [DEPTH];
    logic [DW-1:0]      r_slot_inst [DEPTH];
    logic [DEPTH-1:0]   r_slot_filled;
    logic [c_PTR_W-1:0] r_alloc;
    logic [c_PTR_W-1:0] r_fill;
    logic [c_PTR_W-1:0] r_head;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_pending;
    logic [c_CNT_W-1:0] r_discard;

    logic [AW-1:0]      r_id_pc;
    logic [DW-1:0]      r_id_inst;
    logic               r_id_valid;

    logic [c_CNT_W:0]   w_inflight;
    logic               w_room;
    logic               w_req;
    logic               w_accept;
    logic               w_drop;
    logic               w_fill;
    logic               w_rsp_old;
    logic               w_head_ready;
    logic               w_pop;
    logic               w_bubble;
    logic [DEPTH-1:0]   w_set_mask;
    logic [DEPTH-1:0]   w_clr_mask;
    logic               w_unused_stall;

    // Discarded responses still occupy memory-side slots, so they count against room.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_discard};
    assign w_room     = (w_inflight < c_DEPTH);
    assign w_req      = rst & ce & ~flush & ~stall[0] & w_room;
    assign w_accept   = w_req & inst_gnt;

    assign inst_req    = w_req;
    assign inst_addr   = pc;
    assign stallreq_if = rst & ce & ~flush & ~w_accept;

    assign w_drop       = inst_rvalid & (r_discard != '0);
    assign w_fill       = inst_rvalid & (r_discard == '0) & (r_pending != '0);
    assign w_rsp_old    = w_drop | w_fill;
    assign w_head_ready = r_slot_filled[r_head];
    assign w_pop        = ~flush & ~stall[1] & w_head_ready;
    assign w_bubble     = ~flush & (stall[1] ? ~stall[2] : ~w_head_ready);

    assign w_unused_stall = ^stall[5:3];

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_fill) begin
            w_set_mask[r_fill] = 1'b1;
        end
        if (w_pop) begin
            w_clr_mask[r_head] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alloc       <= '0;
            r_fill        <= '0;
            r_head        <= '0;
            r_count       <= '0;
            r_pending     <= '0;
            r_discard     <= '0;
            r_slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_pc[i]   <= '0;
                r_slot_inst[i] <= '0;
            end
        end else if (flush) begin
            r_alloc       <= '0;
            r_fill        <= '0;
            r_head        <= '0;
            r_count       <= '0;
            r_pending     <= '0;
            r_slot_filled <= '0;
            // A response landing in the flush cycle belongs to the old slots.
            r_discard     <= r_discard + r_pending - c_CNT_W'(w_rsp_old);
        end else begin
            if (w_accept) begin
                r_slot_pc[r_alloc] <= pc;
                r_alloc            <= r_alloc + c_PTR_ONE;
            end
            if (w_fill) begin
                r_slot_inst[r_fill] <= inst_rdata;
                r_fill              <= r_fill + c_PTR_ONE;
            end
            if (w_drop) begin
                r_discard <= r_discard - c_CNT_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            r_slot_filled <= (r_slot_filled | w_set_mask) & ~w_clr_mask;
            r_count       <= r_count + c_CNT_W'(w_accept) - c_CNT_W'(w_pop);
            r_pending     <= r_pending + c_CNT_W'(w_accept) - c_CNT_W'(w_fill);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else if (flush) begin
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end else if (w_pop) begin
            r_id_pc    <= r_slot_pc[r_head];
            r_id_inst  <= r_slot_inst[r_head];
            r_id_valid <= 1'b1;
        end else if (w_bubble) begin
            r_id_inst  <= '0;
            r_id_valid <= 1'b0;
        end
    end

    assign id_pc    = r_id_pc;
    assign id_inst  = r_id_inst;
    assign id_valid = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_buf
// Description : Scoreboard bench for inst_fetch_buf with an in-order memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_buf;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          ce;
    logic [5:0]    stall;
    logic          flush;
    logic          stallreq_if;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_gnt;
    logic          inst_rvalid;
    logic [DW-1:0] inst_rdata;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;
    logic          id_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q [$];
    logic [DW-1:0]    rsp_q [$];
    bit               mem_hold = 1'b0;

    inst_fetch_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .ce          (ce),
        .stall       (stall),
        .flush       (flush),
        .stallreq_if (stallreq_if),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 | (a >> 2);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: sample handshakes away from the edge, score ID, model memory and PC.
    task automatic tick();
        logic             s_acc;
        logic             s_upd;
        logic             s_flush;
        logic [AW-1:0]    s_addr;
        logic [AW+DW-1:0] e;
        @(negedge clk);
        s_acc   = inst_req & inst_gnt;
        s_addr  = inst_addr;
        s_upd   = ~stall[1];
        s_flush = flush;
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            rsp_q.delete();
            inst_rvalid = 1'b0;
            inst_rdata  = '0;
            return;
        end
        if (s_upd && !s_flush && id_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("id_spurious", id_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("id_pc", id_pc, e[AW+DW-1:DW]);
                check_eq("id_inst", id_inst, e[DW-1:0]);
            end
        end
        if (s_flush) exp_q.delete();
        if (s_acc) begin
            rsp_q.push_back(mem_word(s_addr));
            exp_q.push_back({s_addr, mem_word(s_addr)});
            pc = pc + 32'd4;
        end
        if (!mem_hold && rsp_q.size() > 0) begin
            inst_rvalid = 1'b1;
            inst_rdata  = rsp_q.pop_front();
        end else begin
            inst_rvalid = 1'b0;
            inst_rdata  = '0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && rsp_q.size() == 0 && !inst_rvalid) break;
            tick();
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ce = 1'b1; pc = '0; stall = '0; flush = 1'b0;
        inst_gnt = 1'b1; inst_rvalid = 1'b0; inst_rdata = '0;
        #3;
        check_eq("rst_id_valid", id_valid, 0);
        check_eq("rst_id_pc", id_pc, 0);
        check_eq("rst_id_inst", id_inst, 0);
        check_eq("rst_inst_req", inst_req, 0);
        check_eq("rst_stallreq", stallreq_if, 0);
        ce = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // Straight-line fetch of three words.
        pc = 32'h0; ce = 1'b1; inst_gnt = 1'b1;
        for (int i = 0; i < 10 && pc != 32'hC; i++) tick();
        ce = 1'b0;
        check_eq("t1_grants", pc, 32'hC);
        drain("t1_drain");

        // Memory withholds grant: IF must stall with a stable request.
        pc = 32'h10; ce = 1'b1; inst_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t2_stallreq", stallreq_if, 1);
            check_eq("t2_req", inst_req, 1);
            check_eq("t2_addr", inst_addr, 32'h10);
            tick();
        end
        check_eq("t2_pc_hold", pc, 32'h10);
        inst_gnt = 1'b1;
        tick();
        ce = 1'b0;
        check_eq("t2_grant", pc, 32'h14);
        drain("t2_drain");

        // ID stalled: buffer fills to DEPTH, then hold, forced bubble, drain.
        pc = 32'h20; ce = 1'b1; stall = 6'b000110;
        repeat (6) tick();
        #1;
        check_eq("t3_full_req", inst_req, 0);
        check_eq("t3_full_stallreq", stallreq_if, 1);
        check_eq("t3_grants", pc, 32'h30);
        stall = 6'b000000;
        tick();
        stall = 6'b000110;
        tick();
        #1;
        check_eq("t3_hold_valid", id_valid, 1);
        check_eq("t3_hold_pc", id_pc, 32'h20);
        stall = 6'b000010;
        tick();
        #1;
        check_eq("t3_forced_bubble", id_valid, 0);
        check_eq("t3_bubble_inst", id_inst, 0);
        stall = 6'b000000;
        tick(); tick();
        #1;
        check_eq("t3_req_resume", inst_req, 1);
        ce = 1'b0;
        drain("t3_drain");

        // Flush with three requests in flight, then one fresh fetch.
        mem_hold = 1'b1; pc = 32'h40; ce = 1'b1;
        for (int i = 0; i < 10 && pc != 32'h4C; i++) tick();
        check_eq("t4_grants", pc, 32'h4C);
        flush = 1'b1; pc = 32'h100;
        #1;
        check_eq("t4_req_in_flush", inst_req, 0);
        check_eq("t4_stallreq_flush", stallreq_if, 0);
        tick();
        flush = 1'b0;
        #1;
        check_eq("t4_bubble", id_valid, 0);
        tick();
        ce = 1'b0;
        check_eq("t4_grant_new", pc, 32'h104);
        mem_hold = 1'b0;
        drain("t4_drain");
        check_eq("t4_id_pc", id_pc, 32'h100);

        // Accept, fill and pop every cycle at occupancy 2.
        pc = 32'h200; ce = 1'b1; stall = 6'b000110;
        tick(); tick();
        stall = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("t5_req", inst_req, 1);
            tick();
        end
        check_eq("t5_rate", pc, 32'h220);
        ce = 1'b0;
        drain("t5_drain");

        // Asynchronous reset between edges, then restart from a new pc.
        pc = 32'h300; ce = 1'b1;
        repeat (4) tick();
        check_eq("t6_pre_valid", id_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_valid", id_valid, 0);
        check_eq("t6_rst_pc", id_pc, 0);
        check_eq("t6_rst_inst", id_inst, 0);
        check_eq("t6_rst_req", inst_req, 0);
        check_eq("t6_rst_stallreq", stallreq_if, 0);
        exp_q.delete(); rsp_q.delete();
        inst_rvalid = 1'b0; inst_rdata = '0;
        tick();
        rst = 1'b1; pc = 32'h400;
        for (int i = 0; i < 10 && pc != 32'h408; i++) tick();
        ce = 1'b0;
        drain("t6_drain");
        check_eq("t6_id_pc", id_pc, 32'h404);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
